stream_rr_arbiter: RTL

- Shares one downstream valid/ready stream (typically the `din` side of a basic FIFO) between NUM_REQ upstream requesters.
- Grants whole bursts round-robin. A burst ends on an accepted `last` beat or after MAX_BURST beats.
- Sits between per-source producers (e.g. entropy-coder lanes) and a shared output FIFO.
- A per-requester enable mask is provided for configuration.

---
 rtl/qc_arb_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/stream_rr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/qc_arb_pkg.sv
// Shared types and helpers for the stream arbiters.
// Holds the arbiter FSM encoding and the modulo-wrap index increment.
package qc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Index that follows idx in a ring of n entries.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set bit of mask scanning from ptr+1 upward with wrap.
// Rotate so that ptr+1 lands on bit 0, priority-encode, then rotate back.
module rr_priority_pick
  import qc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [REQ_W-1:0]   ptr,
  output logic [REQ_W-1:0]   winner,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;
  int                 start;
  int                 off;

  always_comb begin
    start = next_idx(int'(ptr), NUM_REQ);
    rot   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = mask[REQ_W'((start + k) % NUM_REQ)];
    end
    found = 1'b0;
    off   = 0;
    // Descending scan so the lowest rotated bit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    winner = REQ_W'((start + off) % NUM_REQ);
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst round-robin arbiter sharing one valid/ready stream among NUM_REQ sources.
// A grant lasts until an accepted last beat or MAX_BURST accepted beats.
module stream_rr_arbiter
  import qc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REQ_W      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_W      = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  cfg_en,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_vld,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_rdy,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_vld,
  output logic                                out_last,
  output logic [REQ_W-1:0]                    out_src,
  input  logic                                out_rdy,
  output logic                                busy
);

  arb_state_t         state, state_nx;
  logic [REQ_W-1:0]   grant, grant_nx;
  logic [REQ_W-1:0]   ptr, ptr_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [REQ_W-1:0]   pick_idx;
  logic               pick_found;
  logic               beat_ok;
  logic               burst_end;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_pick (
    .mask   (req_vld & cfg_en),
    .ptr    (ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  assign beat_ok   = (state == ARB_BURST) && req_vld[grant] && out_rdy;
  assign burst_end = beat_ok && (req_last[grant] || (cnt == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= REQ_W'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    req_rdy  = '0;
    out_data = '0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    out_src  = '0;
    busy     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_nx = pick_idx;
          cnt_nx   = '0;
          state_nx = ARB_BURST;
        end
      end
      ARB_BURST: begin
        out_vld        = req_vld[grant];
        out_data       = req_data[grant];
        out_last       = req_last[grant];
        out_src        = grant;
        busy           = 1'b1;
        req_rdy[grant] = out_rdy;
        if (beat_ok) begin
          cnt_nx = cnt + CNT_W'(1);
        end
        // The served requester becomes lowest priority at the next pick.
        if (burst_end) begin
          ptr_nx   = grant;
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

endmodule
